// File: rtl/spireg_regbank_pkg.sv
// ============================================================================
// spireg_pkg : shared constants, FSM encoding and sizing helper. Rev 1.0
// ============================================================================
`default_nettype none

package spireg_pkg;

  localparam logic [5:0] FC_SOFT_RST = 6'h00;
  localparam logic [5:0] FC_CLR_STAT = 6'h01;

  localparam int ST_RO_ERR = 0;
  localparam int ST_COLL   = 1;
  localparam int ST_BUSY   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } arb_state_t;

  function automatic int calc_nreg(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spireg_regbank_if.sv
// ============================================================================
// spireg_regbank_if : SPI-slave and local-requester bus of the register bank. Rev 1.0
// ============================================================================
`default_nettype none

interface spireg_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 16
);
  logic [ADDR_W-1:0] spi_addr;
  logic [REG_W-1:0]  spi_rdata;
  logic [REG_W-1:0]  spi_wdata;
  logic              spi_wvld;
  logic [5:0]        spi_fastcmd;
  logic              spi_fastcmd_vld;
  logic [7:0]        spi_status;
  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [REG_W-1:0]  loc_wdata;
  logic              loc_ack;
  logic [REG_W-1:0]  loc_rdata;

  modport master (
    output spi_addr, spi_wdata, spi_wvld, spi_fastcmd, spi_fastcmd_vld,
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  spi_rdata, spi_status, loc_ack, loc_rdata
  );

  modport slave (
    input  spi_addr, spi_wdata, spi_wvld, spi_fastcmd, spi_fastcmd_vld,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output spi_rdata, spi_status, loc_ack, loc_rdata
  );
endinterface

`default_nettype wire

// File: rtl/spireg_regbank_arb.sv
// ============================================================================
// spireg_regbank_arb : local-port grant FSM, SPI side always has priority. Rev 1.0
// ============================================================================
`default_nettype none

module spireg_regbank_arb
  import spireg_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic loc_req,
  input  logic spi_busy,
  output logic grant,
  output logic coll,
  output logic ack
);

  arb_state_t r_state;
  arb_state_t w_state_nx;

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    grant      = 1'b0;
    coll       = 1'b0;
    case (r_state)
      IDLE: begin
        if (loc_req) begin
          if (spi_busy) begin
            coll = 1'b1;
          end else begin
            grant      = 1'b1;
            w_state_nx = ACK;
          end
        end
      end
      ACK:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign ack = (r_state == ACK);

endmodule

`default_nettype wire

// File: rtl/spireg_regbank.sv
// ============================================================================
// spireg_regbank : register array, fast-command decode and SPI status byte. Rev 1.0
// ============================================================================
`default_nettype none

module spireg_regbank
  import spireg_pkg::*;
#(
  parameter int                      ADDR_W  = 6,
  parameter int                      REG_W   = 16,
  parameter logic [(1<<ADDR_W)-1:0]  RO_MASK = '0
) (
  input  logic                          clk,
  input  logic                          nrst,
  spireg_regbank_if.slave               bus,
  input  logic [3:0]                    usr_status,
  output logic [(1<<ADDR_W)*REG_W-1:0]  regs_flat,
  output logic [5:0]                    fc_code,
  output logic                          fc_strobe
);

  localparam int NREG = calc_nreg(ADDR_W);

  logic [REG_W-1:0] r_regs [NREG];
  logic [REG_W-1:0] r_spi_rdata;
  logic [REG_W-1:0] r_loc_rdata;
  logic [3:0]       r_usr;
  logic             r_ro_err;
  logic             r_coll;
  logic [7:0]       w_status;

  logic w_fc_soft, w_fc_clr, w_fc_user;
  logic w_spi_wr, w_ro_hit, w_spi_busy;
  logic w_grant, w_coll, w_ack;

  assign w_fc_soft  = bus.spi_fastcmd_vld && (bus.spi_fastcmd == FC_SOFT_RST);
  assign w_fc_clr   = bus.spi_fastcmd_vld && (bus.spi_fastcmd == FC_CLR_STAT);
  assign w_fc_user  = bus.spi_fastcmd_vld && !w_fc_soft && !w_fc_clr;
  // A fastcmd overrides a simultaneous write strobe, so the write is dropped.
  assign w_spi_wr   = bus.spi_wvld && !bus.spi_fastcmd_vld;
  assign w_ro_hit   = w_spi_wr && RO_MASK[bus.spi_addr];
  assign w_spi_busy = bus.spi_wvld || w_fc_soft;

  spireg_regbank_arb u_arb (
    .clk      (clk),
    .nrst     (nrst),
    .loc_req  (bus.loc_req),
    .spi_busy (w_spi_busy),
    .grant    (w_grant),
    .coll     (w_coll),
    .ack      (w_ack)
  );

  // Grant is never given while an SPI write is strobed, so the two writes never collide.
  always_ff @(posedge clk) begin
    if (!nrst || w_fc_soft) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_spi_wr && !w_ro_hit)  r_regs[bus.spi_addr] <= bus.spi_wdata;
      if (w_grant && bus.loc_we)  r_regs[bus.loc_addr] <= bus.loc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_spi_rdata <= '0;
      r_loc_rdata <= '0;
      fc_code     <= '0;
      fc_strobe   <= 1'b0;
      r_ro_err    <= 1'b0;
      r_coll      <= 1'b0;
      r_usr       <= usr_status;
    end else begin
      r_spi_rdata <= r_regs[bus.spi_addr];
      if (w_grant && !bus.loc_we) r_loc_rdata <= r_regs[bus.loc_addr];
      fc_strobe <= w_fc_user;
      if (w_fc_user) fc_code <= bus.spi_fastcmd;
      r_usr <= usr_status;
      if (w_fc_clr) begin
        r_ro_err <= 1'b0;
        r_coll   <= 1'b0;
      end else begin
        r_ro_err <= r_ro_err | w_ro_hit;
        r_coll   <= r_coll | w_coll;
      end
    end
  end

  always_comb begin
    w_status            = '0;
    w_status[7:4]       = r_usr;
    w_status[ST_BUSY]   = w_ack;
    w_status[ST_COLL]   = r_coll;
    w_status[ST_RO_ERR] = r_ro_err;
  end

  assign bus.spi_rdata  = r_spi_rdata;
  assign bus.loc_rdata  = r_loc_rdata;
  assign bus.loc_ack    = w_ack;
  assign bus.spi_status = w_status;

  for (genvar n = 0; n < NREG; n++) begin : g_flat
    assign regs_flat[n*REG_W +: REG_W] = r_regs[n];
  end

endmodule

`default_nettype wire
